// File: rtl/gray_decoder_tracker_pkg.sv
// Shared definitions for Gray-code consumers: delta classes and a
// width-agnostic Gray-to-binary helper.
package gray_decoder_tracker_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        DC_HOLD    = 2'd0,
        DC_UP      = 2'd1,
        DC_DN      = 2'd2,
        DC_ILLEGAL = 2'd3
    } delta_class_e;

    // Zero-extended narrower codes convert correctly: leading zeros do not disturb the prefix XOR.
    function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_decoder_tracker_gray2bin_n.sv
// Purely combinational N-bit Gray-to-binary converter.
module gray2bin_n
    import gray_decoder_tracker_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    logic [GRAY_MAX_W-1:0] gray_ext_s;
    logic [GRAY_MAX_W-1:0] bin_ext_s;

    assign gray_ext_s = GRAY_MAX_W'(gray);
    assign bin_ext_s  = gray_to_bin(gray_ext_s);
    assign bin        = N'(bin_ext_s);

endmodule

// File: rtl/gray_decoder_tracker.sv
// Gray-code receiver: samples a Gray word, classifies the step against the
// previous sample and tracks an extended position plus error statistics.
module gray_decoder_tracker
    import gray_decoder_tracker_pkg::*;
#(
    parameter int N = 4,
    parameter int P = 8,
    parameter int E = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic [N-1:0] gray_in,
    input  logic         err_clr,
    output logic [N-1:0] bin_out,
    output logic [P-1:0] pos_out,
    output logic         valid,
    output logic         step_up,
    output logic         step_dn,
    output logic         err,
    output logic         err_sticky,
    output logic [E-1:0] err_cnt
);

    localparam logic [P-1:0] LOW_MASK = P'({N{1'b1}});

    logic [N-1:0]  g_q_r;
    logic          v1_r;
    logic          primed_r;
    logic [N-1:0]  b_s;
    logic [N-1:0]  delta_s;
    delta_class_e  dclass_s;

    logic          primed_n_s;
    logic [N-1:0]  bin_n_s;
    logic [P-1:0]  pos_n_s;
    logic          valid_n_s;
    logic          up_n_s;
    logic          dn_n_s;
    logic          err_n_s;
    logic          sticky_n_s;
    logic [E-1:0]  cnt_n_s;

    gray2bin_n #(.N(N)) u_gray2bin (
        .gray (g_q_r),
        .bin  (b_s)
    );

    // Classify the modular distance between the staged sample and the last accepted one.
    always_comb begin
        delta_s  = b_s - bin_out;
        dclass_s = DC_ILLEGAL;
        if (delta_s == {N{1'b0}}) begin
            dclass_s = DC_HOLD;
        end else if (delta_s == N'(1'b1)) begin
            dclass_s = DC_UP;
        end else if (delta_s == {N{1'b1}}) begin
            dclass_s = DC_DN;
        end else begin
            dclass_s = DC_ILLEGAL;
        end
    end

    // Stage-2 next state: position update, pulses and error bookkeeping.
    always_comb begin
        primed_n_s = primed_r;
        bin_n_s    = bin_out;
        pos_n_s    = pos_out;
        valid_n_s  = 1'b0;
        up_n_s     = 1'b0;
        dn_n_s     = 1'b0;
        err_n_s    = 1'b0;
        sticky_n_s = err_sticky;
        cnt_n_s    = err_cnt;

        if (v1_r) begin
            valid_n_s = 1'b1;
            bin_n_s   = b_s;
            if (!primed_r) begin
                primed_n_s = 1'b1;
                pos_n_s    = P'(b_s);
            end else begin
                case (dclass_s)
                    DC_HOLD: pos_n_s = pos_out;
                    DC_UP: begin
                        up_n_s  = 1'b1;
                        pos_n_s = pos_out + P'(1'b1);
                    end
                    DC_DN: begin
                        dn_n_s  = 1'b1;
                        pos_n_s = pos_out - P'(1'b1);
                    end
                    default: begin
                        // Resync the low bits to the code, keep the wrap count above it.
                        err_n_s = 1'b1;
                        pos_n_s = (pos_out & ~LOW_MASK) | P'(b_s);
                    end
                endcase
            end
        end else begin
            valid_n_s = 1'b0;
        end

        // A fresh error at the same edge as a clear is kept as the first counted error.
        if (err_clr) begin
            sticky_n_s = err_n_s;
            cnt_n_s    = err_n_s ? E'(1'b1) : {E{1'b0}};
        end else if (err_n_s) begin
            sticky_n_s = 1'b1;
            cnt_n_s    = (err_cnt == {E{1'b1}}) ? err_cnt : err_cnt + E'(1'b1);
        end else begin
            sticky_n_s = err_sticky;
            cnt_n_s    = err_cnt;
        end
    end

    // Stage-1 capture and stage-2 output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_q_r      <= {N{1'b0}};
            v1_r       <= 1'b0;
            primed_r   <= 1'b0;
            bin_out    <= {N{1'b0}};
            pos_out    <= {P{1'b0}};
            valid      <= 1'b0;
            step_up    <= 1'b0;
            step_dn    <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= {E{1'b0}};
        end else begin
            v1_r       <= clk_en;
            if (clk_en) begin
                g_q_r <= gray_in;
            end
            primed_r   <= primed_n_s;
            bin_out    <= bin_n_s;
            pos_out    <= pos_n_s;
            valid      <= valid_n_s;
            step_up    <= up_n_s;
            step_dn    <= dn_n_s;
            err        <= err_n_s;
            err_sticky <= sticky_n_s;
            err_cnt    <= cnt_n_s;
        end
    end

endmodule

// File: tb/tb_gray_decoder_tracker.sv
// Self-checking bench for gray_decoder_tracker (N=4, P=8, E=4): directed
// scenarios followed by randomized traffic against a behavioural model.
module tb_gray_decoder_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_en = 1'b0;
    logic [3:0] gray_in = 4'd0;
    logic       err_clr = 1'b0;
    logic [3:0] bin_out;
    logic [7:0] pos_out;
    logic       valid, step_up, step_dn, err, err_sticky;
    logic [3:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_bin, m_pos, m_cnt;
    bit m_valid, m_up, m_dn, m_err, m_sticky, m_primed;
    bit pend_v;
    int pend_g;
    int cur_bin;

    gray_decoder_tracker #(.N(4), .P(8), .E(4)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .gray_in(gray_in), .err_clr(err_clr),
        .bin_out(bin_out), .pos_out(pos_out), .valid(valid), .step_up(step_up),
        .step_dn(step_dn), .err(err), .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int g2b(input int g);
        int b = 0;
        for (int k = 0; k < 4; k++) b = b ^ (g >> k);
        return b & 15;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit en, input int g, input bit clr);
        int b, d;
        if (r) begin
            m_bin = 0; m_pos = 0; m_cnt = 0; m_valid = 0; m_up = 0; m_dn = 0;
            m_err = 0; m_sticky = 0; m_primed = 0; pend_v = 0; pend_g = 0;
            return;
        end
        m_valid = 0; m_up = 0; m_dn = 0; m_err = 0;
        if (pend_v) begin
            b = g2b(pend_g);
            m_valid = 1;
            if (!m_primed) begin
                m_primed = 1;
                m_pos = b;
            end else begin
                d = (b - m_bin + 16) % 16;
                if (d == 1) begin m_up = 1; m_pos = m_pos + 1; end
                else if (d == 15) begin m_dn = 1; m_pos = m_pos - 1; end
                else if (d != 0) begin m_err = 1; m_pos = (m_pos / 16) * 16 + b; end
            end
            m_pos = (m_pos + 256) % 256;
            m_bin = b;
        end
        if (clr) begin
            m_sticky = m_err;
            m_cnt = m_err ? 1 : 0;
        end else if (m_err) begin
            m_sticky = 1;
            if (m_cnt < 15) m_cnt = m_cnt + 1;
        end
        pend_v = en;
        if (en) pend_g = g;
    endtask

    task automatic cycle(input bit r, input bit en, input int g, input bit clr);
        rst = r; clk_en = en; gray_in = 4'(g); err_clr = clr;
        @(posedge clk);
        model_edge(r, en, g, clr);
        #1;
        check("bin_out", 32'(bin_out), 32'(m_bin));
        check("pos_out", 32'(pos_out), 32'(m_pos));
        check("valid", 32'(valid), 32'(m_valid));
        check("step_up", 32'(step_up), 32'(m_up));
        check("step_dn", 32'(step_dn), 32'(m_dn));
        check("err", 32'(err), 32'(m_err));
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
        check("err_cnt", 32'(err_cnt), 32'(m_cnt));
    endtask

    initial begin
        int r, nb;
        // reset and count 0..3
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("reset_pos", 32'(pos_out), 32'h0);
        cycle(0, 1, 4'b0000, 0);
        cycle(0, 1, 4'b0001, 0);
        cycle(0, 1, 4'b0011, 0);
        cycle(0, 1, 4'b0010, 0);
        cycle(0, 0, 4'b0010, 0);
        check("count_bin", 32'(bin_out), 32'd3);
        check("count_pos", 32'(pos_out), 32'h03);

        // wrap down and back up
        cycle(1, 0, 0, 0);
        cycle(0, 1, 4'b0000, 0);
        cycle(0, 1, 4'b1000, 0);
        cycle(0, 1, 4'b0000, 0);
        check("wrap_dn", 32'(step_dn), 32'd1);
        check("wrap_dn_pos", 32'(pos_out), 32'hFF);
        cycle(0, 0, 4'b0000, 0);
        check("wrap_up", 32'(step_up), 32'd1);
        check("wrap_up_pos", 32'(pos_out), 32'h00);

        // single illegal jump
        cycle(1, 0, 0, 0);
        cycle(0, 1, 4'b0000, 0);
        cycle(0, 1, 4'b0011, 0);
        cycle(0, 0, 4'b0011, 0);
        check("ill_err", 32'(err), 32'd1);
        check("ill_cnt", 32'(err_cnt), 32'd1);
        check("ill_pos", 32'(pos_out), 32'h02);

        // saturation, then clear coinciding with a new error
        for (int i = 0; i < 20; i++) cycle(0, 1, (i % 2 == 0) ? 4'b1100 : 4'b0011, 0);
        check("sat_cnt", 32'(err_cnt), 32'd15);
        cycle(0, 1, 4'b0011, 1);
        check("clr_cnt", 32'(err_cnt), 32'd1);
        check("clr_sticky", 32'(err_sticky), 32'd1);
        cycle(0, 0, 4'b0011, 1);
        cycle(0, 0, 4'b0011, 0);
        check("clr_only", 32'(err_sticky), 32'd0);

        // enable held low while the input toggles
        for (int i = 0; i < 5; i++) cycle(0, 0, $urandom_range(0, 15), 0);
        cycle(0, 1, 4'b0010, 0);
        cycle(0, 0, 4'b1111, 0);
        check("reen_bin", 32'(bin_out), 32'd3);

        // count to 0x15, reset, re-prime
        cycle(1, 0, 0, 0);
        for (int i = 0; i <= 16'h15; i++) cycle(0, 1, b2g(i % 16), 0);
        cycle(0, 0, 0, 0);
        check("cnt15_pos", 32'(pos_out), 32'h15);
        cycle(1, 1, 4'b0110, 0);
        check("rst_pos", 32'(pos_out), 32'h0);
        cycle(0, 1, 4'b0110, 0);
        cycle(0, 0, 4'b0110, 0);
        check("reprime_pos", 32'(pos_out), 32'h04);
        check("reprime_err", 32'(err), 32'd0);

        // randomized traffic, mostly legal steps
        cur_bin = 4;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) nb = cur_bin + 1;
            else if (r < 6) nb = cur_bin + 15;
            else if (r < 8) nb = cur_bin;
            else nb = $urandom_range(0, 15);
            cur_bin = nb % 16;
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  b2g(cur_bin), ($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
